// File: rtl/fifo_pkg.sv
// Shared types for the parametrised synchronous FIFO: controller state encoding.
package fifo_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array FIFO storage: synchronous write port, asynchronous read port.
// Storage is deliberately not reset; contents are only meaningful behind the FIFO pointers.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read gives first-word-fall-through on the head entry.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FWFT FIFO with occupancy count, almost flags and accept-while-full.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic [1:0]       diag_state
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  fifo_state_t   state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  // Accept decisions depend only on registered state; a full FIFO takes a write only alongside a pop.
  always_comb begin
    wr_ok = 1'b0;
    rd_ok = 1'b0;
    case (state_q)
      EMPTY: begin
        wr_ok = write;
      end
      PARTIAL: begin
        wr_ok = write;
        rd_ok = read;
      end
      FULL: begin
        rd_ok = read;
        wr_ok = write & read;
      end
      default: begin
        wr_ok = 1'b0;
        rd_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (wr_ok) state_d = PARTIAL;
      end
      PARTIAL: begin
        if (rd_ok && !wr_ok && count_q == CW'(1)) begin
          state_d = EMPTY;
        end else if (wr_ok && !rd_ok && count_q == CW'(DEPTH - 1)) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (rd_ok && !wr_ok) state_d = PARTIAL;
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    waddr_d = waddr_q + AW'(wr_ok);
    raddr_d = raddr_q + AW'(rd_ok);
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (waddr_q),
    .wdata_i (wdata),
    .raddr_i (raddr_q),
    .rdata_o (rdata)
  );

  assign empty        = (state_q == EMPTY);
  assign full         = (state_q == FULL);
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign count        = count_q;
  assign diag_state   = state_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (write & ~wr_ok);
      underflow_q <= underflow_q | (read & ~rd_ok);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: queue-based reference model with per-cycle comparison,
// directed scenarios on an 8x4 instance and randomized traffic on a 16x8 instance.
module tb_fifo_sync_param;

  localparam int DA = 4;
  localparam int DB = 8;
  localparam int AF_B = 6;
  localparam int AE_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_a = 1'b0, rd_a = 1'b0;
  logic [7:0]  wd_a = '0;
  logic [7:0]  rdata_a;
  logic        empty_a, full_a, ae_a, af_a;
  logic [2:0]  count_a;
  logic [1:0]  diag_a;

  logic        wr_b = 1'b0, rd_b = 1'b0;
  logic [15:0] wd_b = '0;
  logic [15:0] rdata_b;
  logic        empty_b, full_b, ae_b, af_b;
  logic [3:0]  count_b;
  logic [1:0]  diag_b;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_a, unf_a, ovf_b, unf_b;
`endif

  fifo_sync_param u_dut_a (
    .clk(clk), .rst(rst), .write(wr_a), .wdata(wd_a), .read(rd_a),
    .rdata(rdata_a), .empty(empty_a), .full(full_a),
    .almost_empty(ae_a), .almost_full(af_a), .count(count_a), .diag_state(diag_a)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf_a), .underflow(unf_a)
`endif
  );

  fifo_sync_param #(.WIDTH(16), .DEPTH(DB), .AF_LEVEL(AF_B), .AE_LEVEL(AE_B)) u_dut_b (
    .clk(clk), .rst(rst), .write(wr_b), .wdata(wd_b), .read(rd_b),
    .rdata(rdata_b), .empty(empty_b), .full(full_b),
    .almost_empty(ae_b), .almost_full(af_b), .count(count_b), .diag_state(diag_b)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf_b), .underflow(unf_b)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO is a queue; a pop needs content, a push needs room or a same-cycle pop.
  logic [7:0]  qa[$];
  logic [15:0] qb[$];
  bit model_ok = 0;
  bit ovf_am = 0, unf_am = 0, ovf_bm = 0, unf_bm = 0;
  bit rok_a, wok_a, rok_b, wok_b;

  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      ovf_am = 0; unf_am = 0; ovf_bm = 0; unf_bm = 0;
      model_ok = 1;
    end else begin
      rok_a = rd_a && (qa.size() > 0);
      wok_a = wr_a && ((qa.size() < DA) || rok_a);
      if (rd_a && !rok_a) unf_am = 1;
      if (wr_a && !wok_a) ovf_am = 1;
      if (rok_a) void'(qa.pop_front());
      if (wok_a) qa.push_back(wd_a);

      rok_b = rd_b && (qb.size() > 0);
      wok_b = wr_b && ((qb.size() < DB) || rok_b);
      if (rd_b && !rok_b) unf_bm = 1;
      if (wr_b && !wok_b) ovf_bm = 1;
      if (rok_b) void'(qb.pop_front());
      if (wok_b) qb.push_back(wd_b);
    end
  end

  function automatic logic [1:0] exp_state(input int n, input int depth);
    if (n == 0) return 2'd0;
    if (n == depth) return 2'd2;
    return 2'd1;
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      chk("a_count", 32'(count_a), 32'(qa.size()));
      chk("a_empty", 32'(empty_a), 32'(qa.size() == 0));
      chk("a_full", 32'(full_a), 32'(qa.size() == DA));
      chk("a_almost_empty", 32'(ae_a), 32'(qa.size() <= 1));
      chk("a_almost_full", 32'(af_a), 32'(qa.size() >= 3));
      chk("a_state", 32'(diag_a), 32'(exp_state(qa.size(), DA)));
      if (qa.size() > 0) chk("a_rdata", 32'(rdata_a), 32'(qa[0]));
      chk("b_count", 32'(count_b), 32'(qb.size()));
      chk("b_empty", 32'(empty_b), 32'(qb.size() == 0));
      chk("b_full", 32'(full_b), 32'(qb.size() == DB));
      chk("b_almost_empty", 32'(ae_b), 32'(qb.size() <= AE_B));
      chk("b_almost_full", 32'(af_b), 32'(qb.size() >= AF_B));
      chk("b_state", 32'(diag_b), 32'(exp_state(qb.size(), DB)));
      if (qb.size() > 0) chk("b_rdata", 32'(rdata_b), 32'(qb[0]));
`ifdef FIFO_ERR_FLAGS_EN
      chk("a_overflow", 32'(ovf_a), 32'(ovf_am));
      chk("a_underflow", 32'(unf_a), 32'(unf_am));
      chk("b_overflow", 32'(ovf_b), 32'(ovf_bm));
      chk("b_underflow", 32'(unf_b), 32'(unf_bm));
`endif
    end
  end

  task automatic step_a(input logic w, input logic [7:0] d, input logic r);
    wr_a = w; wd_a = d; rd_a = r;
    @(posedge clk); #1;
    wr_a = 1'b0; rd_a = 1'b0;
  endtask

  logic [7:0] drain [4] = '{8'hB2, 8'hC3, 8'hD4, 8'h66};
  int wp;

  initial begin
    rst = 1'b1;
    step_a(0, 8'h00, 0);
    step_a(0, 8'h00, 0);
    rst = 1'b0;
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_ae", 32'(ae_a), 32'd1);
    chk("rst_af", 32'(af_a), 32'd0);
    $display("reset done count=%0d empty=%0d", count_a, empty_a);

    step_a(1, 8'hA1, 0);
    chk("w1_count", 32'(count_a), 32'd1);
    chk("w1_rdata", 32'(rdata_a), 32'hA1);
    step_a(1, 8'hB2, 0);
    chk("w2_af", 32'(af_a), 32'd0);
    step_a(1, 8'hC3, 0);
    chk("w3_af", 32'(af_a), 32'd1);
    chk("w3_full", 32'(full_a), 32'd0);
    step_a(1, 8'hD4, 0);
    chk("w4_full", 32'(full_a), 32'd1);
    chk("w4_count", 32'(count_a), 32'd4);
    chk("w4_rdata", 32'(rdata_a), 32'hA1);
    $display("fill A1..D4 count=%0d full=%0d rdata=%h", count_a, full_a, rdata_a);

    step_a(1, 8'h55, 0);
    chk("ovf_count", 32'(count_a), 32'd4);
    chk("ovf_rdata", 32'(rdata_a), 32'hA1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 32'(ovf_a), 32'd1);
`endif
    $display("write 55 while full count=%0d rdata=%h", count_a, rdata_a);

    step_a(1, 8'h66, 1);
    chk("rw_full_count", 32'(count_a), 32'd4);
    chk("rw_full_rdata", 32'(rdata_a), 32'hB2);
    $display("read+write 66 while full count=%0d rdata=%h", count_a, rdata_a);

    for (int i = 0; i < 4; i++) begin
      chk("drain_rdata", 32'(rdata_a), 32'(drain[i]));
      $display("drain pop rdata=%h", rdata_a);
      step_a(0, 8'h00, 1);
    end
    chk("drain_empty", 32'(empty_a), 32'd1);

    step_a(1, 8'h77, 1);
    chk("rw_empty_count", 32'(count_a), 32'd1);
    chk("rw_empty_rdata", 32'(rdata_a), 32'h77);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_flag", 32'(unf_a), 32'd1);
`endif
    $display("read+write 77 while empty count=%0d rdata=%h", count_a, rdata_a);
    step_a(0, 8'h00, 1);
    chk("pop77_empty", 32'(empty_a), 32'd1);

    step_a(1, 8'h11, 0);
    step_a(1, 8'h22, 0);
    step_a(1, 8'h33, 0);
    chk("midfill_count", 32'(count_a), 32'd3);
    rst = 1'b1;
    step_a(1, 8'h44, 1);
    rst = 1'b0;
    chk("midrst_count", 32'(count_a), 32'd0);
    chk("midrst_empty", 32'(empty_a), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("midrst_ovf", 32'(ovf_a), 32'd0);
    chk("midrst_unf", 32'(unf_a), 32'd0);
`endif
    step_a(1, 8'hE5, 0);
    chk("e5_rdata", 32'(rdata_a), 32'hE5);
    chk("e5_count", 32'(count_a), 32'd1);
    $display("reset mid-fill then write E5 rdata=%h", rdata_a);

    // Alternate write-heavy and read-heavy phases so both FIFOs hit full, empty and wrap.
    for (int cyc = 0; cyc < 800; cyc++) begin
      wp = ((cyc / 100) % 2 == 0) ? 75 : 30;
      rst  = (cyc == 450);
      wr_a = ($urandom_range(0, 99) < wp);
      rd_a = ($urandom_range(0, 99) < 100 - wp);
      wd_a = 8'($urandom);
      wr_b = ($urandom_range(0, 99) < wp);
      rd_b = ($urandom_range(0, 99) < 100 - wp);
      wd_b = 16'($urandom);
      @(posedge clk); #1;
      if (cyc % 100 == 99)
        $display("random cyc=%0d count_a=%0d count_b=%0d", cyc, count_a, count_b);
    end
    rst = 1'b0;
    wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
